com_link_host: RTL and testbench

- Host-side end of the core-array load/unload protocol. It accepts an input word stream and drives the array's load interface: com_data_in, data_write_start and data_write_done.
- It then waits for the array to finish, and captures the com_data_out unload burst, framed by output_write_start and output_write_done.
- Captured words leave on a valid/ready stream through an internal FIFO.
- Sits between the external I/O adapter and the multi-core top level.

---
 rtl/com_link_host_pkg.sv | 35 +++
 rtl/com_link_fifo.sv | 75 +++++++
 rtl/com_link_host.sv | 203 ++++++++++++++++++++
 tb/tb_com_link_host.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/com_link_host_pkg.sv
// com_link_host_pkg
//   Shared definitions for the host-side load/unload link:
//   - state_t      : controller FSM states
//   - ERR_*        : bit positions inside the sticky err vector
//   - MS_*         : encodings of the array's main_state phase input
//   - CNT_W        : width of the load and capture word counters
//   - min1_clog2() : counter width helper that never returns 0
package com_link_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_GAP     = 3'd2,
        ST_LOAD    = 3'd3,
        ST_ACK     = 3'd4,
        ST_RUN     = 3'd5,
        ST_CAPTURE = 3'd6,
        ST_DRAIN   = 3'd7
    } state_t;

    localparam int ERR_UNDERRUN    = 0;
    localparam int ERR_ACK_TIMEOUT = 1;
    localparam int ERR_OVERFLOW    = 2;

    localparam logic [1:0] MS_LOAD = 2'b00;
    localparam logic [1:0] MS_RUN  = 2'b01;
    localparam logic [1:0] MS_IDLE = 2'b11;

    localparam int CNT_W = 11;

    function automatic int min1_clog2(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/com_link_fifo.sv
// com_link_fifo
//   Show-ahead synchronous FIFO for captured words. The MSB of each entry is
//   the "last" tag; tail_last_set sets that tag on the newest entry after it
//   was written (the end of a burst is only known once done arrives).
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     push, push_data write request / entry (ignored when full unless popping)
//     pop             read request (ignored when empty)
//     tail_last_set   set the last tag of the newest stored entry
//     head_data       oldest entry, last tag already merged with tail_last_set
//     full, empty     occupancy flags
module com_link_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             tail_last_set,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    tail_idx;
    logic             do_push;
    logic             do_pop;
    logic             tail_is_head;

    assign wr_idx   = wr_ptr_q[AW-1:0];
    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign tail_idx = wr_idx - AW'(1);

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

    // A push into a full FIFO is accepted when the head leaves the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // With a single entry stored, the tag being set right now must already be
    // visible at the head so the final word is not presented untagged.
    assign tail_is_head = !empty && (rd_idx == tail_idx);
    assign head_data = {mem[rd_idx][WIDTH-1] | (tail_last_set & tail_is_head),
                        mem[rd_idx][WIDTH-2:0]};

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= push_data;
        end
        if (tail_last_set && !empty) begin
            mem[tail_idx][WIDTH-1] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/com_link_host.sv
// com_link_host
//   Host end of the core-array load/unload protocol. Streams a load burst into
//   the array, waits for it to run, captures the unload burst and forwards the
//   captured words on a valid/ready stream through com_link_fifo.
//   Optional build macro: COM_LINK_CHECKSUM_EN (16-bit modular sum of every
//   word written into the FIFO; tied to 0 when undefined).
//   Ports:
//     clk, rst_n                       clock, asynchronous active-low reset
//     in_data/in_valid/in_last/in_ready load word stream
//     com_data_in, data_write_start,
//     data_write_done                  array load interface
//     com_data_out, main_state,
//     output_write_start/_done         array run/unload interface
//     out_data/out_valid/out_last/out_ready captured word stream
//     busy                             controller not in IDLE
//     err                              sticky {overflow, ack_timeout, underrun}
//     checksum                         sum of captured words (optional)
//     dbg_state                        controller FSM state
//   Stream handshake: a word moves when valid & ready are both high on a rising
//   clock edge; while valid is high and ready low, data/last/valid hold.
//   On the load side in_ready is high only in load slots; a slot with
//   in_valid low is not retried, it becomes a zero word (underrun).
module com_link_host
    import com_link_host_pkg::*;
#(
    parameter int IN_WORDS    = 1024,
    parameter int OUT_WORDS   = 1024,
    parameter int SKIP        = 0,
    parameter int FIFO_DEPTH  = 16,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] com_data_in,
    output logic        data_write_start,
    output logic        data_write_done,
    input  logic [15:0] com_data_out,
    input  logic [1:0]  main_state,
    input  logic        output_write_start,
    input  logic        output_write_done,
    output logic [15:0] out_data,
    output logic        out_valid,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic [2:0]  err,
    output logic [15:0] checksum,
    output logic [2:0]  dbg_state
);

    localparam int SKIP_W = min1_clog2(SKIP + 1);
    localparam int ACK_W  = min1_clog2(ACK_TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   ld_cnt_q, cap_cnt_q;
    logic [SKIP_W-1:0]  skip_cnt_q;
    logic [ACK_W-1:0]   ack_cnt_q;
    logic [15:0]        wdata_q;
    logic               done_q;
    logic [2:0]         err_q;
    logic               ows_q;
    logic               armed_q;

    logic start_xfer, load_slot, final_word;
    logic ows_rise, cap_active, eligible, skip_done;
    logic push_evt, push_last, overflow;
    logic ack_ok, ack_expire;
    logic fifo_full, fifo_empty, fifo_pop, fifo_tail_set;
    logic [16:0] fifo_head;

    assign start_xfer = (state_q == ST_IDLE) && in_valid;

    // Load slots: GAP samples word 0, each LOAD cycle samples the next word
    // until the final one has been registered onto com_data_in.
    assign load_slot  = (state_q == ST_GAP) || ((state_q == ST_LOAD) && !done_q);
    assign final_word = (in_valid && in_last) || (ld_cnt_q == CNT_W'(IN_WORDS - 1));

    // armed_q stays low after reset until the array has been seen quiet in
    // IDLE, so a burst left over from an abandoned transfer is never captured.
    assign ows_rise   = output_write_start && !ows_q && armed_q;
    // The rising-edge cycle already carries the first unload word.
    assign cap_active = (state_q == ST_CAPTURE) || ((state_q == ST_RUN) && ows_rise);
    assign eligible   = cap_active && output_write_start && !output_write_done;
    assign skip_done  = (skip_cnt_q == SKIP_W'(SKIP));
    assign push_evt   = eligible && skip_done;
    assign push_last  = push_evt && (cap_cnt_q == CNT_W'(OUT_WORDS - 1));

    assign fifo_pop      = !fifo_empty && out_ready;
    assign overflow      = push_evt && fifo_full && !fifo_pop;
    // Done after the final push: tag whatever word is newest in the FIFO.
    assign fifo_tail_set = (state_q == ST_CAPTURE) && output_write_done &&
                           (cap_cnt_q != '0);

    assign ack_ok     = (main_state == MS_RUN);
    assign ack_expire = !ack_ok && (ack_cnt_q == ACK_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (in_valid) state_d = ST_START;
            ST_START:   state_d = ST_GAP;
            ST_GAP:     state_d = ST_LOAD;
            ST_LOAD:    if (done_q) state_d = ST_ACK;
            ST_ACK:     if (ack_ok || ack_expire) state_d = ST_RUN;
            ST_RUN:     if (ows_rise) state_d = push_last ? ST_DRAIN : ST_CAPTURE;
            ST_CAPTURE: if (output_write_done || push_last) state_d = ST_DRAIN;
            ST_DRAIN:   if (fifo_empty) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ld_cnt_q   <= '0;
            cap_cnt_q  <= '0;
            skip_cnt_q <= '0;
            ack_cnt_q  <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= '0;
            ows_q      <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ows_q   <= output_write_start;
            if ((state_q == ST_IDLE) && !output_write_start && !output_write_done) begin
                armed_q <= 1'b1;
            end

            if (start_xfer) begin
                err_q      <= '0;
                ld_cnt_q   <= '0;
                cap_cnt_q  <= '0;
                skip_cnt_q <= '0;
                ack_cnt_q  <= '0;
            end else begin
                if (load_slot && !in_valid)            err_q[ERR_UNDERRUN]    <= 1'b1;
                if ((state_q == ST_ACK) && ack_expire) err_q[ERR_ACK_TIMEOUT] <= 1'b1;
                if (overflow)                          err_q[ERR_OVERFLOW]    <= 1'b1;
                if (load_slot)                ld_cnt_q   <= ld_cnt_q + CNT_W'(1);
                if (state_q == ST_ACK)        ack_cnt_q  <= ack_cnt_q + ACK_W'(1);
                if (eligible && !skip_done)   skip_cnt_q <= skip_cnt_q + SKIP_W'(1);
                if (push_evt)                 cap_cnt_q  <= cap_cnt_q + CNT_W'(1);
            end

            if (load_slot) begin
                wdata_q <= in_valid ? in_data : 16'h0000;
                done_q  <= final_word;
            end else begin
                wdata_q <= 16'h0000;
                done_q  <= 1'b0;
            end
        end
    end

    com_link_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (17)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .push          (push_evt),
        .push_data     ({push_last, com_data_out}),
        .pop           (fifo_pop),
        .tail_last_set (fifo_tail_set),
        .head_data     (fifo_head),
        .full          (fifo_full),
        .empty         (fifo_empty)
    );

`ifdef COM_LINK_CHECKSUM_EN
    logic [15:0] csum_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (start_xfer) begin
            csum_q <= '0;
        end else if (push_evt && (!fifo_full || fifo_pop)) begin
            csum_q <= csum_q + com_data_out;
        end
    end
    assign checksum = csum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign in_ready         = load_slot;
    assign com_data_in      = wdata_q;
    assign data_write_start = (state_q == ST_START);
    assign data_write_done  = done_q;
    assign out_valid        = !fifo_empty;
    assign out_data         = fifo_empty ? 16'h0000 : fifo_head[15:0];
    assign out_last         = !fifo_empty && fifo_head[16];
    assign busy             = (state_q != ST_IDLE);
    assign err              = err_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_com_link_host.sv
module tb_com_link_host;
    import com_link_host_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [15:0] in_data;
    logic        in_valid, in_last, in_ready;
    logic [15:0] com_data_in;
    logic        data_write_start, data_write_done;
    logic [15:0] com_data_out;
    logic [1:0]  main_state;
    logic        output_write_start, output_write_done;
    logic [15:0] out_data;
    logic        out_valid, out_last, out_ready;
    logic        busy;
    logic [2:0]  err;
    logic [15:0] checksum;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_sum4, exp_sum5;

    com_link_host dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_data            (in_data),
        .in_valid           (in_valid),
        .in_last            (in_last),
        .in_ready           (in_ready),
        .com_data_in        (com_data_in),
        .data_write_start   (data_write_start),
        .data_write_done    (data_write_done),
        .com_data_out       (com_data_out),
        .main_state         (main_state),
        .output_write_start (output_write_start),
        .output_write_done  (output_write_done),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_last           (out_last),
        .out_ready          (out_ready),
        .busy               (busy),
        .err                (err),
        .checksum           (checksum),
        .dbg_state          (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_com_data_in"}, com_data_in, 0);
        chk({tag, "_dws"}, data_write_start, 0);
        chk({tag, "_dwd"}, data_write_done, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_checksum"}, checksum, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
`ifdef COM_LINK_CHECKSUM_EN
        exp_sum4 = 16'h003C;
        exp_sum5 = 16'h1078;
`else
        exp_sum4 = 16'h0000;
        exp_sum5 = 16'h0000;
`endif
        rst_n = 1'b0;
        in_data = '0; in_valid = 1'b0; in_last = 1'b0;
        com_data_out = '0; main_state = MS_IDLE;
        output_write_start = 1'b0; output_write_done = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        chk_all_zero("reset");
        chk("reset_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        tick();

        // ---- 1: three-word load A1,B2,C3 ----
        in_valid = 1'b1; in_data = 16'h00A1;
        tick();                                   // S
        chk("t1_dws_S", data_write_start, 1);
        chk("t1_ready_S", in_ready, 0);
        tick();                                   // S+1 GAP, A1 sampled
        chk("t1_dws_S1", data_write_start, 0);
        chk("t1_gap_data", com_data_in, 0);
        chk("t1_ready_S1", in_ready, 1);
        tick();                                   // S+2
        chk("t1_word0", com_data_in, 16'h00A1);
        chk("t1_dwd_S2", data_write_done, 0);
        in_data = 16'h00B2;
        tick();                                   // S+3
        chk("t1_word1", com_data_in, 16'h00B2);
        chk("t1_dwd_S3", data_write_done, 0);
        in_data = 16'h00C3; in_last = 1'b1;
        tick();                                   // S+4
        chk("t1_word2", com_data_in, 16'h00C3);
        chk("t1_dwd_S4", data_write_done, 1);
        chk("t1_ready_S4", in_ready, 0);
        in_valid = 1'b0; in_last = 1'b0;
        main_state = MS_RUN;
        tick();                                   // S+5 ACK
        chk("t1_dwd_S5", data_write_done, 0);
        chk("t1_ack_state", dbg_state, ST_ACK);
        tick();                                   // S+6 RUN
        chk("t1_run_state", dbg_state, ST_RUN);
        chk("t1_err", err, 0);

        // ---- 4: unload 10..14, out_ready=1 ----
        main_state = MS_IDLE;
        for (int i = 0; i < 5; i++) exp_q.push_back(16'(10 + i));
        for (int i = 0; i < 5; i++) begin
            output_write_start = 1'b1;
            com_data_out = 16'(10 + i);
            tick();
            chk("t4_valid", out_valid, 1);
            chk("t4_data", out_data, exp_q.pop_front());
            chk("t4_last_early", out_last, 0);
        end
        output_write_done = 1'b1;
        #1;
        chk("t4_last_data", out_data, 16'd14);
        chk("t4_last_tag", out_last, 1);
        tick();                                   // DRAIN
        output_write_start = 1'b0; output_write_done = 1'b0;
        chk("t4_drained", out_valid, 0);
        chk("t4_checksum", checksum, exp_sum4);
        chk("t4_err", err, 0);
        tick();
        chk("t4_idle", busy, 0);

        // ---- 2 + 3: underrun at word 1, ack timeout ----
        in_valid = 1'b1; in_data = 16'h5A5A;
        tick();                                   // S
        chk("t2_dws", data_write_start, 1);
        chk("t2_err_cleared", err, 0);
        tick();                                   // S+1
        tick();                                   // S+2
        chk("t2_word0", com_data_in, 16'h5A5A);
        in_valid = 1'b0;
        tick();                                   // S+3
        chk("t2_underrun_word", com_data_in, 0);
        chk("t2_err0", err, 3'b001);
        chk("t2_dwd_S3", data_write_done, 0);
        in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b1;
        tick();                                   // S+4
        chk("t2_word2", com_data_in, 16'h1234);
        chk("t2_dwd_S4", data_write_done, 1);
        in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 4; i++) begin         // S+5..S+8 in ACK
            tick();
            chk("t3_ack_wait", dbg_state, ST_ACK);
            chk("t3_err_pending", err, 3'b001);
        end
        tick();                                   // S+9
        chk("t3_err1", err, 3'b011);
        chk("t3_run", dbg_state, ST_RUN);

        // ---- 5: 20-word burst into a stalled 16-entry FIFO ----
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            output_write_start = 1'b1;
            com_data_out = 16'(16'h0100 + i);
            if (i < 16) exp_q.push_back(16'(16'h0100 + i));
            tick();
        end
        chk("t5_err", err, 3'b111);
        chk("t5_hold_data", out_data, 16'h0100);
        chk("t5_hold_last", out_last, 0);
        output_write_done = 1'b1;
        tick();                                   // DRAIN
        output_write_start = 1'b0; output_write_done = 1'b0;
        chk("t5_drain_state", dbg_state, ST_DRAIN);
        chk("t5_hold_data2", out_data, 16'h0100);
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("t5_valid", out_valid, 1);
            chk("t5_data", out_data, exp_q.pop_front());
            chk("t5_last", out_last, (j == 15) ? 1 : 0);
            tick();
        end
        chk("t5_empty", out_valid, 0);
        chk("t5_checksum", checksum, exp_sum5);
        tick();
        chk("t5_idle", busy, 0);

        // ---- 6: reset mid-LOAD, residual burst ignored ----
        in_valid = 1'b1; in_data = 16'h7777;
        tick(); tick(); tick();                   // S, GAP, LOAD
        chk("t6_loading", com_data_in, 16'h7777);
        output_write_start = 1'b1; com_data_out = 16'hDEAD;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_reset");
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            output_write_done = (i == 4);
            tick();
            chk("t6_busy", busy, 0);
            chk("t6_out_valid", out_valid, 0);
        end
        output_write_start = 1'b0; output_write_done = 1'b0;
        tick();
        chk("t6_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
